// File: rtl/mem_store_queue_if.sv
// mem_store_queue_if: execute-stage request/response bundle for mem_store_queue.
interface mem_store_queue_if #(
    parameter int ADDR_LEN = 8,
    parameter int DATA_LEN = 64
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic                req_we_i;
    logic [2:0]          req_funct3_i;
    logic [ADDR_LEN-1:0] req_addr_i;
    logic [DATA_LEN-1:0] req_wdata_i;
    logic                rsp_valid_o;
    logic [DATA_LEN-1:0] rsp_data_o;

    modport master (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/mem_store_queue.sv
// mem_store_queue: in-order store queue sharing one Memory port between loads and store drains.
// Optional STQ_FWD_EN lets a load that matches a queued DWRD store take its data from the queue.
module mem_store_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_LEN = 8,
    parameter int DATA_LEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_store_queue_if.slave    req,
    output logic                mem_wen_o,
    output logic [2:0]          mem_funct3_o,
    output logic [ADDR_LEN-1:0] mem_waddr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic [ADDR_LEN-1:0] mem_raddr_o,
    input  logic [DATA_LEN-1:0] mem_rdata_i,
    output logic                empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [2:0] SEL_DWRD = 3'b011;

    typedef struct packed {
        logic [ADDR_LEN-1:0] addr;
        logic [2:0]          funct3;
        logic [DATA_LEN-1:0] data;
        logic                valid;
    } entry_t;

    entry_t [DEPTH-1:0]  ent_q, ent_d;
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                match, fwd_hit, ld_ok, load_acc, store_acc, port_load, drain;
    logic [DATA_LEN-1:0] ld_data;

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            match = match | (ent_q[i].valid && ent_q[i].addr == req.req_addr_i);
    end

`ifdef STQ_FWD_EN
    localparam logic [2:0] SEL_BYTE = 3'b000, SEL_HALF = 3'b001, SEL_WORD = 3'b010;
    localparam logic [2:0] SEL_BYTU = 3'b100, SEL_HLFU = 3'b101, SEL_WRDU = 3'b110;

    logic                fwd_dwrd;
    logic [DATA_LEN-1:0] fwd_data;

    function automatic logic [DATA_LEN-1:0] ext(input logic [DATA_LEN-1:0] d, input logic [2:0] f);
        return f == SEL_BYTE ? {{(DATA_LEN-8){d[7]}}, d[7:0]}
             : f == SEL_HALF ? {{(DATA_LEN-16){d[15]}}, d[15:0]}
             : f == SEL_WORD ? {{(DATA_LEN-32){d[31]}}, d[31:0]}
             : f == SEL_BYTU ? {{(DATA_LEN-8){1'b0}}, d[7:0]}
             : f == SEL_HLFU ? {{(DATA_LEN-16){1'b0}}, d[15:0]}
             : f == SEL_WRDU ? {{(DATA_LEN-32){1'b0}}, d[31:0]}
             : d;
    endfunction

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        fwd_dwrd = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ent_q[head_q + PW'(i)].valid && ent_q[head_q + PW'(i)].addr == req.req_addr_i) begin
                fwd_dwrd = ent_q[head_q + PW'(i)].funct3 == SEL_DWRD;
                fwd_data = ent_q[head_q + PW'(i)].data;
            end
    end

    assign fwd_hit = match && fwd_dwrd;
    assign ld_data = fwd_hit ? ext(fwd_data, req.req_funct3_i) : mem_rdata_i;
`else
    assign fwd_hit = 1'b0;
    assign ld_data = mem_rdata_i;
`endif

    assign ld_ok     = req.req_valid_i && !req.req_we_i && cnt_q != FULL && (!match || fwd_hit);
    assign load_acc  = rst_n && ld_ok;
    assign store_acc = rst_n && req.req_valid_i && req.req_we_i && cnt_q < FULL;
    assign port_load = load_acc && !fwd_hit;
    // Gating on rst_n idles the port so queued stores are dropped before reaching Memory.
    assign drain     = rst_n && !port_load && cnt_q != '0;

    assign req.req_ready_o = req.req_we_i ? cnt_q < FULL : ld_ok;
    assign req.rsp_valid_o = rsp_valid_q;
    assign req.rsp_data_o  = rsp_data_q;
    assign empty_o         = cnt_q == '0;

    always_comb begin
        mem_wen_o    = !drain;
        mem_funct3_o = port_load ? req.req_funct3_i : drain ? ent_q[head_q].funct3 : SEL_DWRD;
        mem_waddr_o  = drain ? ent_q[head_q].addr : '0;
        mem_wdata_o  = drain ? ent_q[head_q].data : '0;
        mem_raddr_o  = port_load ? req.req_addr_i : '0;
    end

    always_comb begin
        ent_d = ent_q;
        if (drain) ent_d[head_q].valid = 1'b0;
        if (store_acc) ent_d[tail_q] = '{req.req_addr_i, req.req_funct3_i, req.req_wdata_i, 1'b1};
        head_d      = head_q + PW'(drain);
        tail_d      = tail_q + PW'(store_acc);
        cnt_d       = cnt_q + (PW+1)'(store_acc) - (PW+1)'(drain);
        rsp_valid_d = load_acc;
        rsp_data_d  = load_acc ? ld_data : rsp_data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end
endmodule
